// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state type and counter sizing for the PLL reset sequencer
//
// Purpose : types and helpers imported by pll_reset_sequencer.
// Ports   : none (package).

package pll_seq_pkg;

  // Sequencer states. RESET_PLL is the reset state and the target of every
  // restart (lock loss, lock timeout, soft reset).
  typedef enum logic [1:0] {
    ST_RESET_PLL = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_STABLE    = 2'd2,
    ST_RUN       = 2'd3
  } seq_state_e;

  // Saturation value of the lock-loss counter.
  localparam logic [7:0] LOSS_CNT_MAX = 8'hFF;

  // Width of the shared cycle counter: wide enough to hold the largest of the
  // three programmable intervals.
  function automatic int lock_cnt_w(input int rst_cycles,
                                    input int stable_cycles,
                                    input int timeout_cycles);
    int max_cycles;
    max_cycles = rst_cycles;
    if (stable_cycles > max_cycles) max_cycles = stable_cycles;
    if (timeout_cycles > max_cycles) max_cycles = timeout_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - parameterized-depth single-bit synchronizer
//
// Purpose : brings an asynchronous level into the clk domain through a flop
//           chain of STAGES flops; all flops reset to 0.
// Ports   : clk   in  1  destination clock
//           rst_n in  1  asynchronous active-low reset
//           d     in  1  asynchronous input level
//           q     out 1  synchronized level (last flop of the chain)

module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift toward the MSB; bit 0 is the metastability-catching flop.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and core reset release
//
// Purpose : pulses the PLL reset, waits for lock, qualifies lock for a
//           programmable time and then releases the core reset. Lock loss or
//           lock timeout restarts the sequence. Runs on the reference clock.
// Ports   : clk_74a         in  1  reference clock (same source as PLL refclk)
//           reset_n         in  1  asynchronous active-low reset
//           pll_locked      in  1  PLL lock indicator, asynchronous
//           soft_reset      in  1  one-cycle synchronous restart request
//           pll_rst         out 1  active-high PLL reset
//           core_reset_n    out 1  active-low reset for downstream core logic
//           pll_ready       out 1  high while in RUN
//           lock_loss_count out 8  saturating count of lock losses seen in RUN
//           timeout_flag    out 1  sticky lock-timeout indicator

module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 742500
) (
  input  logic       clk_74a,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       core_reset_n,
  output logic       pll_ready,
  output logic [7:0] lock_loss_count,
  output logic       timeout_flag
);

  localparam int CNT_W = lock_cnt_w(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                    LOCK_TIMEOUT_CYCLES);

  // Counter value on the last cycle of each interval; the transition fires on
  // the edge that ends that cycle, so the interval spans exactly N edges.
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic locked_s;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_cnt_q, loss_cnt_d;
  logic             timeout_q, timeout_d;
  logic             pll_rst_q, pll_rst_d;
  logic             run_q, run_d;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk_74a),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    loss_cnt_d = loss_cnt_q;
    timeout_d  = timeout_q;

    if (soft_reset) begin
      // Restart wins over every other transition, including a lock loss or
      // timeout in the same cycle, so neither statistic is updated.
      state_d   = ST_RESET_PLL;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        ST_RESET_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end

        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d   = ST_RESET_PLL;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end
        end

        ST_STABLE: begin
          // A lock dropout during qualification is not counted as a loss;
          // the wait simply restarts with a fresh timeout window.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end

        ST_RUN: begin
          cnt_d = '0;
          if (!locked_s) begin
            state_d = ST_RESET_PLL;
            if (loss_cnt_q != LOSS_CNT_MAX) begin
              loss_cnt_d = loss_cnt_q + 8'd1;
            end
          end
        end

        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register and come straight from flops.
    pll_rst_d = (state_d == ST_RESET_PLL);
    run_d     = (state_d == ST_RUN);
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RESET_PLL;
      cnt_q      <= '0;
      loss_cnt_q <= '0;
      timeout_q  <= 1'b0;
      pll_rst_q  <= 1'b1;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      loss_cnt_q <= loss_cnt_d;
      timeout_q  <= timeout_d;
      pll_rst_q  <= pll_rst_d;
      run_q      <= run_d;
    end
  end

  assign pll_rst         = pll_rst_q;
  assign core_reset_n    = run_q;
  assign pll_ready       = run_q;
  assign lock_loss_count = loss_cnt_q;
  assign timeout_flag    = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed scoreboard bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int RSTC = 4;
  localparam int STBC = 8;
  localparam int TOC  = 32;

  logic       clk_74a = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       soft_reset;
  logic       pll_rst;
  logic       core_reset_n;
  logic       pll_ready;
  logic [7:0] lock_loss_count;
  logic       timeout_flag;

  always #5 clk_74a = ~clk_74a;

  pll_reset_sequencer #(
    .SYNC_STAGES         (SYNC),
    .PLL_RST_CYCLES      (RSTC),
    .LOCK_STABLE_CYCLES  (STBC),
    .LOCK_TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk_74a         (clk_74a),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .soft_reset      (soft_reset),
    .pll_rst         (pll_rst),
    .core_reset_n    (core_reset_n),
    .pll_ready       (pll_ready),
    .lock_loss_count (lock_loss_count),
    .timeout_flag    (timeout_flag)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_pop(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("FAIL sb_empty: observed=%0d expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        tests_failed++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_74a);
    #1;
  endtask

  function automatic logic sel_sig(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return core_reset_n;
      default: return pll_ready;
    endcase
  endfunction

  // Counts edges until the selected output reaches val; -1 if the bound expires.
  task automatic edges_until(input int sel, input logic val, input int limit,
                             output int n);
    n = 0;
    forever begin
      tick();
      n++;
      if (sel_sig(sel) === val) break;
      if (n >= limit) begin
        n = -1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   to_cnt;
    logic rel_seen;

    reset_n    = 1'b0;
    pll_locked = 1'b0;
    soft_reset = 1'b0;
    repeat (3) tick();

    // Reset values.
    expect_val("rst_pll_rst", 1);
    expect_val("rst_core_reset_n", 0);
    expect_val("rst_pll_ready", 0);
    expect_val("rst_loss_cnt", 0);
    expect_val("rst_timeout", 0);
    check_pop(32'(pll_rst));
    check_pop(32'(core_reset_n));
    check_pop(32'(pll_ready));
    check_pop(32'(lock_loss_count));
    check_pop(32'(timeout_flag));

    // First pulse after reset release.
    reset_n = 1'b1;
    expect_val("por_rst_pulse", RSTC);
    expect_val("por_timeout_clear", 0);
    edges_until(0, 1'b0, 50, n);
    check_pop(32'(n));
    check_pop(32'(timeout_flag));

    // Lock never asserts: timeout cycle repeats with period RSTC+TOC.
    expect_val("to_low1", TOC);
    expect_val("to_flag_set", 1);
    expect_val("to_high1", RSTC);
    expect_val("to_low2", TOC);
    expect_val("to_flag_sticky", 1);
    expect_val("to_high2", RSTC);
    edges_until(0, 1'b1, 100, n);
    check_pop(32'(n));
    check_pop(32'(timeout_flag));
    edges_until(0, 1'b0, 100, n);
    check_pop(32'(n));
    edges_until(0, 1'b1, 100, n);
    check_pop(32'(n));
    check_pop(32'(timeout_flag));
    edges_until(0, 1'b0, 100, n);
    check_pop(32'(n));

    // Lock rises at cycle 10 of WAIT_LOCK.
    repeat (9) tick();
    pll_locked = 1'b1;
    expect_val("lock_release_edges", SYNC + STBC);
    expect_val("lock_pll_ready", 1);
    expect_val("lock_loss_cnt", 0);
    tick();
    edges_until(1, 1'b1, 100, n);
    check_pop(32'(n));
    check_pop(32'(pll_ready));
    check_pop(32'(lock_loss_count));

    // Lock loss in RUN.
    pll_locked = 1'b0;
    expect_val("loss_fall_edges", SYNC);
    expect_val("loss_pll_rst", 1);
    expect_val("loss_rst_pulse", RSTC);
    expect_val("loss_cnt_1", 1);
    tick();
    edges_until(1, 1'b0, 20, n);
    check_pop(32'(n));
    check_pop(32'(pll_rst));
    edges_until(0, 1'b0, 20, n);
    check_pop(32'(n));
    check_pop(32'(lock_loss_count));

    // Soft reset on the edge the synchronized lock drops in RUN.
    pll_locked = 1'b1;
    expect_val("soft_relock_edges", SYNC + STBC);
    tick();
    edges_until(1, 1'b1, 100, n);
    check_pop(32'(n));
    pll_locked = 1'b0;
    tick();
    tick();
    soft_reset = 1'b1;
    expect_val("soft_pll_rst", 1);
    expect_val("soft_core_reset_n", 0);
    expect_val("soft_loss_cnt", 1);
    expect_val("soft_timeout_clr", 0);
    expect_val("soft_rst_pulse_rest", RSTC);
    tick();
    soft_reset = 1'b0;
    check_pop(32'(pll_rst));
    check_pop(32'(core_reset_n));
    check_pop(32'(lock_loss_count));
    check_pop(32'(timeout_flag));
    edges_until(0, 1'b0, 20, n);
    check_pop(32'(n));

    // Lock glitch during qualification: 5 high, 3 low, then relock.
    rel_seen   = 1'b0;
    pll_locked = 1'b1;
    repeat (5) begin
      tick();
      if (core_reset_n !== 1'b0) rel_seen = 1'b1;
    end
    pll_locked = 1'b0;
    repeat (3) begin
      tick();
      if (core_reset_n !== 1'b0) rel_seen = 1'b1;
    end
    expect_val("glitch_no_release", 0);
    expect_val("glitch_loss_cnt", 1);
    expect_val("glitch_requal_edges", SYNC + STBC);
    check_pop(32'(rel_seen));
    check_pop(32'(lock_loss_count));
    pll_locked = 1'b1;
    tick();
    edges_until(1, 1'b1, 100, n);
    check_pop(32'(n));

    // Repeated lock losses saturate the counter.
    to_cnt = 0;
    for (int i = 0; i < 258; i++) begin
      pll_locked = 1'b0;
      edges_until(0, 1'b1, 20, n);
      if (n < 0) to_cnt++;
      edges_until(0, 1'b0, 20, n);
      if (n < 0) to_cnt++;
      if (i == 9) begin
        expect_val("sat_loss_cnt_mid", 11);
        check_pop(32'(lock_loss_count));
      end
      pll_locked = 1'b1;
      edges_until(1, 1'b1, 40, n);
      if (n < 0) to_cnt++;
    end
    expect_val("sat_loss_cnt", 255);
    expect_val("sat_wait_timeouts", 0);
    expect_val("sat_timeout_flag", 0);
    check_pop(32'(lock_loss_count));
    check_pop(32'(to_cnt));
    check_pop(32'(timeout_flag));

    // Asynchronous reset mid-STABLE.
    pll_locked = 1'b0;
    edges_until(0, 1'b1, 20, n);
    edges_until(0, 1'b0, 20, n);
    pll_locked = 1'b1;
    repeat (5) tick();
    expect_val("ares_pll_rst", 1);
    expect_val("ares_core_reset_n", 0);
    expect_val("ares_pll_ready", 0);
    expect_val("ares_loss_cnt", 0);
    expect_val("ares_timeout", 0);
    expect_val("ares_rst_pulse", RSTC);
    #3;
    reset_n = 1'b0;
    #1;
    check_pop(32'(pll_rst));
    check_pop(32'(core_reset_n));
    check_pop(32'(pll_ready));
    check_pop(32'(lock_loss_count));
    check_pop(32'(timeout_flag));
    #2;
    reset_n = 1'b1;
    edges_until(0, 1'b0, 20, n);
    check_pop(32'(n));

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("FAIL sb_leftover: observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
